// File: rtl/adder_pkg.sv
// Shared types for the multi-precision add sequencer.
// FSM encoding and count-width helper.
package adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_bka_r2.sv
// Radix-2 Brent-Kung adder: po = a + b + ci, WIDTH+1 bits.
// A 3:2 stage folds ci in so the prefix tree sees two operands.
module adder_bka_r2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] ci,
  output logic [WIDTH:0]   po
);

  localparam int TOP = 1 << $clog2(WIDTH);

  logic [WIDTH-1:0] x, y, cs, g, c;

  assign x  = a ^ b ^ ci;
  assign cs = (a & b) | (a & ci) | (b & ci);
  assign y  = {cs[WIDTH-2:0], 1'b0};

  always_comb begin
    logic [WIDTH-1:0] gg, pp;
    gg = x & y;
    pp = x ^ y;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = 2*d-1; i < WIDTH; i = i + 2*d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = TOP / 2; d > 0; d = d / 2) begin
      for (int i = 3*d-1; i < WIDTH; i = i + 2*d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    g = gg;
  end

  assign c  = {g[WIDTH-2:0], 1'b0};
  // cs MSB carries weight 2^WIDTH and lands directly on the top bit
  assign po = {g[WIDTH-1] ^ cs[WIDTH-1], x ^ y ^ c};

endmodule

// File: rtl/adder_mp_seq.sv
// Multi-precision add sequencer over one shared WIDTH-bit core.
// Optional subtract port under ADDER_SUBTRACT_EN.
module adder_mp_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH*WORDS-1:0] s_a,
  input  logic [WIDTH*WORDS-1:0] s_b,
  input  logic                   s_ci,
`ifdef ADDER_SUBTRACT_EN
  input  logic                   s_sub,
`endif
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*WORDS-1:0] m_sum,
  output logic                   m_co,
  output logic                   busy
);

  localparam int N  = WIDTH * WORDS;
  localparam int CW = clog2_min1(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t           state, state_nxt;
  logic [N-1:0]     op_a, op_b, sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, carry_init, inv, last, accept;
  logic [WIDTH:0]   po;
  logic [WIDTH-1:0] core_b, core_ci;

  assign accept = (state == ST_IDLE) && s_valid;
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (s_valid) state_nxt = ST_RUN;
      ST_RUN:  if (last)    state_nxt = ST_DONE;
      ST_DONE: if (m_ready) state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b0;
    unique case (state)
      ST_IDLE: s_ready = 1'b1;
      ST_RUN:  busy    = 1'b1;
      ST_DONE: begin
        m_valid = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ADDER_SUBTRACT_EN
  logic sub_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     sub_q <= 1'b0;
    else if (accept) sub_q <= s_sub;
  end
  assign inv        = sub_q;
  assign carry_init = s_sub | s_ci;
`else
  assign inv        = 1'b0;
  assign carry_init = s_ci;
`endif

  assign core_b  = op_b[WIDTH-1:0] ^ {WIDTH{inv}};
  assign core_ci = {{(WIDTH-1){1'b0}}, carry};

  adder_bka_r2 #(.WIDTH(WIDTH)) u_core (
    .a  (op_a[WIDTH-1:0]),
    .b  (core_b),
    .ci (core_ci),
    .po (po)
  );

  // result words enter at the top so word k ends at k*WIDTH
  if (WORDS == 1) begin : g_one
    assign sum_nxt = po[WIDTH-1:0];
  end else begin : g_multi
    assign sum_nxt = {po[WIDTH-1:0], m_sum[N-1:WIDTH]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      m_sum <= '0;
      m_co  <= 1'b0;
    end else if (accept) begin
      op_a  <= s_a;
      op_b  <= s_b;
      carry <= carry_init;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      op_a  <= op_a >> WIDTH;
      op_b  <= op_b >> WIDTH;
      carry <= po[WIDTH];
      cnt   <= cnt + 1'b1;
      m_sum <= sum_nxt;
      if (last) m_co <= po[WIDTH];
    end
  end

endmodule
